// File: rtl/idct_decoder.sv
// idct_decoder: serial-in / serial-out 8x8 block decoder.
// Dequantises 64 raster-order coefficients with the 50%-quality table, runs a
// separable 2D IDCT (row pass then column pass) on a single shared MAC, and
// streams the 64 reconstructed pixels back out on read requests.
module idct_decoder #(
  parameter int DW   = 10,
  parameter int CW   = 9,
  parameter int FRAC = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enin,
  input  logic signed [DW-1:0] datain,
  input  logic                 enout,
  output logic signed [DW-1:0] dataout,
  output logic                 valid_out,
  output logic                 busy,
  output logic                 done
);

  localparam int AW = 30;
  localparam int IW = 18;

  localparam logic signed [AW-1:0] HALF  = AW'(2 ** (FRAC - 1));
  localparam logic signed [AW-1:0] R_MAX = AW'(2 ** (IW - 1) - 1);
  localparam logic signed [AW-1:0] R_MIN = -R_MAX - AW'(1);
  localparam logic signed [AW-1:0] P_MAX = AW'(2 ** (DW - 1) - 1);
  localparam logic signed [AW-1:0] P_MIN = -P_MAX - AW'(1);

  localparam logic [6:0] Q_TAB [64] = '{
    7'd16, 7'd11, 7'd10, 7'd16, 7'd24, 7'd40, 7'd51, 7'd61,
    7'd12, 7'd12, 7'd14, 7'd19, 7'd26, 7'd58, 7'd60, 7'd55,
    7'd14, 7'd13, 7'd16, 7'd24, 7'd40, 7'd57, 7'd69, 7'd56,
    7'd14, 7'd17, 7'd22, 7'd29, 7'd51, 7'd87, 7'd80, 7'd62,
    7'd18, 7'd22, 7'd37, 7'd56, 7'd68, 7'd109, 7'd103, 7'd77,
    7'd24, 7'd35, 7'd55, 7'd64, 7'd81, 7'd104, 7'd113, 7'd92,
    7'd49, 7'd64, 7'd78, 7'd87, 7'd103, 7'd121, 7'd120, 7'd101,
    7'd72, 7'd92, 7'd95, 7'd98, 7'd112, 7'd100, 7'd103, 7'd99
  };

  typedef enum logic [1:0] {S_LOAD, S_ROW, S_COL, S_OUT} state_t;

  // 128*cos(m*pi/16) for the first quadrant, m = 0..8
  function automatic logic signed [CW-1:0] cos_mag(input logic [3:0] m);
    case (m)
      4'd0:    cos_mag = CW'(128);
      4'd1:    cos_mag = CW'(126);
      4'd2:    cos_mag = CW'(118);
      4'd3:    cos_mag = CW'(106);
      4'd4:    cos_mag = CW'(91);
      4'd5:    cos_mag = CW'(71);
      4'd6:    cos_mag = CW'(49);
      4'd7:    cos_mag = CW'(25);
      default: cos_mag = CW'(0);
    endcase
  endfunction

  // C[x][k]: fold the angle (2x+1)k mod 32 back into the first quadrant
  function automatic logic signed [CW-1:0] cos_rom(input logic [2:0] x, input logic [2:0] k);
    logic [4:0] m;
    m = {1'b0, x, 1'b1} * {2'b00, k};
    if (k == 3'd0)
      cos_rom = CW'(91);
    else if (m <= 5'd8)
      cos_rom = cos_mag(m[3:0]);
    else if (m <= 5'd16)
      cos_rom = -cos_mag(4'(5'd16 - m));
    else if (m <= 5'd24)
      cos_rom = -cos_mag(4'(m - 5'd16));
    else
      cos_rom = cos_mag(4'(5'd0 - m));
  endfunction

  state_t               state_q, state_d;
  logic [8:0]           cnt_q, cnt_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [DW-1:0] dataout_q, dataout_d;
  logic                 valid_out_q, valid_out_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic signed [IW-1:0] d_mem [64];
  logic signed [IW-1:0] r_mem [64];
  logic signed [DW-1:0] p_mem [64];

  logic signed [IW-1:0] d_val;
  logic signed [IW-1:0] mac_op;
  logic signed [CW-1:0] coef;
  logic signed [AW-1:0] prod;
  logic signed [AW-1:0] acc_sum;
  logic signed [AW-1:0] rnd;
  logic signed [IW-1:0] row_sat;
  logic signed [DW-1:0] pix_sat;
  logic                 d_we, r_we, p_we;

  // MAC datapath: operand select, product, accumulate, round and saturate
  always_comb begin
    d_val = {{(IW - DW){datain[DW-1]}}, datain} * {11'b0, Q_TAB[cnt_q[5:0]]};
    coef  = cos_rom(cnt_q[5:3], cnt_q[2:0]);
    case (state_q)
      S_ROW:   mac_op = d_mem[{cnt_q[8:6], cnt_q[2:0]}];
      S_COL:   mac_op = r_mem[{cnt_q[2:0], cnt_q[8:6]}];
      default: mac_op = '0;
    endcase
    prod    = $signed({{(AW - CW){coef[CW-1]}}, coef}) * $signed({{(AW - IW){mac_op[IW-1]}}, mac_op});
    acc_sum = (cnt_q[2:0] == 3'd0) ? prod : acc_q + prod;
    rnd     = (acc_sum + HALF) >>> FRAC;
    if (rnd > R_MAX)      row_sat = IW'(R_MAX);
    else if (rnd < R_MIN) row_sat = IW'(R_MIN);
    else                  row_sat = rnd[IW-1:0];
    if (rnd > P_MAX)      pix_sat = DW'(P_MAX);
    else if (rnd < P_MIN) pix_sat = DW'(P_MIN);
    else                  pix_sat = rnd[DW-1:0];
    d_we = (state_q == S_LOAD) && enin;
    r_we = (state_q == S_ROW) && (cnt_q[2:0] == 3'd7);
    p_we = (state_q == S_COL) && (cnt_q[2:0] == 3'd7);
  end

  // Next-state and registered-output logic for the LOAD/ROW/COL/OUT sequence
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    dataout_d   = dataout_q;
    valid_out_d = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (enin) begin
          cnt_d = cnt_q + 9'd1;
          if (cnt_q == 9'd63) begin
            cnt_d   = '0;
            state_d = S_ROW;
            busy_d  = 1'b1;
          end
        end
      end
      S_ROW: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 9'd1;
        if (cnt_q == 9'd511) state_d = S_COL;
      end
      S_COL: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 9'd1;
        if (cnt_q == 9'd511) begin
          state_d = S_OUT;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_OUT: begin
        if (enout) begin
          dataout_d   = p_mem[cnt_q[5:0]];
          valid_out_d = 1'b1;
          cnt_d       = cnt_q + 9'd1;
          if (cnt_q == 9'd63) begin
            cnt_d   = '0;
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // Control and output registers; reset aborts any block in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOAD;
      cnt_q       <= '0;
      acc_q       <= '0;
      dataout_q   <= '0;
      valid_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      dataout_q   <= dataout_d;
      valid_out_q <= valid_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Block buffers: dequantised input, row-pass result, final pixels
  always_ff @(posedge clk) begin
    if (d_we) d_mem[cnt_q[5:0]] <= d_val;
    if (r_we) r_mem[{cnt_q[8:6], cnt_q[5:3]}] <= row_sat;
    if (p_we) p_mem[{cnt_q[5:3], cnt_q[8:6]}] <= pix_sat;
  end

  assign dataout   = dataout_q;
  assign valid_out = valid_out_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_idct_decoder.sv
// tb_idct_decoder: scoreboard bench for idct_decoder.
// Expected pixels are queued when a block is loaded and popped as valid_out
// delivers them; expected values are hand-derived DC and first-harmonic cases.
module tb_idct_decoder;

  localparam int DW = 10;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 enin;
  logic signed [DW-1:0] datain;
  logic                 enout;
  logic signed [DW-1:0] dataout;
  logic                 valid_out;
  logic                 busy;
  logic                 done;

  int checks = 0;
  int errors = 0;
  int expQ[$];
  int coefIn[64];
  int pixExp[64];
  int validBusy = 0;
  int rowPat[8] = '{2, 2, 1, 0, 0, -1, -2, -2};

  idct_decoder #(.DW(DW), .CW(9), .FRAC(8)) dut (
    .clk(clk),
    .rst(rst),
    .enin(enin),
    .datain(datain),
    .enout(enout),
    .dataout(dataout),
    .valid_out(valid_out),
    .busy(busy),
    .done(done)
  );

  // 10-unit clock period
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic setDcBlock(input int dc, input int pix);
    for (int i = 0; i < 64; i++) begin
      coefIn[i] = 0;
      pixExp[i] = pix;
    end
    coefIn[0] = dc;
  endtask

  // Load one block; gapMode inserts an idle cycle (with junk data) between samples
  task automatic applyStimulus(input bit gapMode, input bit pushExp);
    if (pushExp)
      for (int i = 0; i < 64; i++) expQ.push_back(pixExp[i]);
    for (int i = 0; i < 64; i++) begin
      enin   = 1'b1;
      datain = DW'(coefIn[i]);
      @(posedge clk); #1;
      if (gapMode && i != 63) begin
        enin   = 1'b0;
        datain = DW'($urandom);
        @(posedge clk); #1;
      end
    end
    enin   = 1'b0;
    datain = '0;
  endtask

  // Latency counts edges from the one that takes the last sample up to the one raising done
  task automatic waitDone(input bit noise, input string tag);
    int lat = 1;
    int busyCnt = 0;
    bit got = 0;
    for (int c = 0; c < 3000; c++) begin
      if (busy) busyCnt++;
      if (valid_out) validBusy++;
      if (noise && busy) begin
        enin   = 1'b1;
        enout  = 1'b1;
        datain = DW'($urandom);
      end else begin
        enin  = 1'b0;
        enout = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (done) begin
        got = 1;
        break;
      end
    end
    enin   = 1'b0;
    enout  = 1'b0;
    datain = '0;
    checkOutput({tag, "_done_seen"}, int'(got), 1);
    checkOutput({tag, "_latency"}, lat, 1025);
    checkOutput({tag, "_busy_cycles"}, busyCnt, 1024);
    @(posedge clk); #1;
    checkOutput({tag, "_done_pulse"}, int'(done), 0);
  endtask

  // Read a whole block; gapMode toggles enout and checks dataout holds while idle
  task automatic readBlock(input bit gapMode, input string tag);
    int n = 0;
    int lastPix = 0;
    int e;
    for (int c = 0; c < 400 && n < 64; c++) begin
      enout = gapMode ? ((c % 2) == 0) : 1'b1;
      @(posedge clk); #1;
      if (valid_out) begin
        if (expQ.size() == 0) begin
          checkOutput({tag, "_extra_pixel"}, 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput($sformatf("%s_pix%0d", tag, n), int'(dataout), e);
          lastPix = e;
        end
        n++;
      end else if (gapMode && n > 0) begin
        checkOutput({tag, "_hold"}, int'(dataout), lastPix);
      end
    end
    enout = 1'b0;
    checkOutput({tag, "_read_count"}, n, 64);
    enout = 1'b1;
    @(posedge clk); #1;
    checkOutput({tag, "_enout_in_load"}, int'(valid_out), 0);
    enout = 1'b0;
  endtask

  task automatic runBlock(input bit gapMode, input string tag);
    applyStimulus(gapMode, 1'b1);
    waitDone(gapMode, tag);
    readBlock(gapMode, tag);
  endtask

  initial begin
    rst    = 1'b1;
    enin   = 1'b0;
    enout  = 1'b0;
    datain = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_dataout", int'(dataout), 0);
    checkOutput("rst_valid", int'(valid_out), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] all-zero block");
    setDcBlock(0, 0);
    runBlock(1'b0, "zero");

    $display("[TB] DC=2 block");
    setDcBlock(2, 4);
    runBlock(1'b0, "dc2");

    $display("[TB] DC=-2 block");
    setDcBlock(-2, -4);
    runBlock(1'b0, "dcm2");

    $display("[TB] coefficient [0][1]=1");
    setDcBlock(0, 0);
    coefIn[1] = 1;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) pixExp[y * 8 + x] = rowPat[x];
    runBlock(1'b0, "h01");

    $display("[TB] coefficient [1][0]=1");
    setDcBlock(0, 0);
    coefIn[8] = 1;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) pixExp[y * 8 + x] = rowPat[y];
    runBlock(1'b0, "h10");

    $display("[TB] DC=511 block");
    setDcBlock(511, 511);
    runBlock(1'b0, "dc511");

    $display("[TB] DC=2 with gaps and stray requests while busy");
    setDcBlock(2, 4);
    runBlock(1'b1, "gap");

    $display("[TB] DC=-512 block");
    setDcBlock(-512, -512);
    runBlock(1'b0, "dcm512");

    $display("[TB] reset mid-ROW");
    setDcBlock(511, 511);
    applyStimulus(1'b0, 1'b0);
    repeat (100) @(posedge clk);
    #1;
    checkOutput("abort_busy_before", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_dataout", int'(dataout), 0);
    checkOutput("abort_valid", int'(valid_out), 0);
    checkOutput("abort_done", int'(done), 0);
    setDcBlock(2, 4);
    runBlock(1'b0, "after_abort");

    checkOutput("valid_while_busy", validBusy, 0);
    checkOutput("queue_empty", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
